// File: rtl/rtc_bus_master_if.sv
// rtc_bus_master_if: register-port handshake, irq and RTC strobes (start/rw/addr/len/wdata/irq in; busy/done/rdata/rvalid/wnext/irq_pulse/CS/AD/RD/WR out)
interface rtc_bus_master_if #(parameter int DATA_W = 8, parameter int BURST_W = 4);
  logic start, rw, irq;
  logic [DATA_W-1:0] addr, wdata, rdata;
  logic [BURST_W-1:0] len;
  logic busy, done, rvalid, wnext, irq_pulse;
  logic CS, AD, RD, WR;
  modport master(input start, rw, addr, len, wdata, irq,
                 output busy, done, rdata, rvalid, wnext, irq_pulse, CS, AD, RD, WR);
  modport slave(output start, rw, addr, len, wdata, irq,
                input busy, done, rdata, rvalid, wnext, irq_pulse, CS, AD, RD, WR);
endinterface

// File: rtl/rtc_bus_master.sv
// rtc_bus_master: RTC muxed-bus burst master (clk, reset, bus: rtc_bus_master_if.master, datRTC: tristate address/data pins) with synchronised irq edge pulse
module rtc_bus_master #(
  parameter int DATA_W    = 8,
  parameter int PHASE_CYC = 10,
  parameter int BURST_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_master_if.master   bus,
  inout  wire [DATA_W-1:0]   datRTC
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_DATA, S_RECOV} state_t;
  localparam int CW = $clog2(PHASE_CYC);
  state_t r_st, w_ns;
  logic [CW-1:0] r_cnt;
  logic [BURST_W-1:0] r_beats;
  logic [DATA_W-1:0] r_addr, w_addr_n, r_dout, r_rdata;
  logic r_rw, r_oe, r_cs, r_ad, r_rd, r_wr, r_done, r_rvalid, r_wnext;
  logic r_s1, r_s2, r_s3, r_irq_pulse;
  logic w_last, w_enter;
  always_comb begin
    w_last = r_cnt == CW'(PHASE_CYC - 1);
    w_ns = r_st;
    if (r_st == S_IDLE) w_ns = bus.start ? S_ADDR : S_IDLE;
    else if (w_last) w_ns = r_st == S_ADDR ? S_GAP :
                            r_st == S_GAP  ? S_DATA :
                            r_st == S_DATA ? S_RECOV :
                            r_beats == '0  ? S_IDLE : S_ADDR;
    w_enter = w_ns != r_st;
    w_addr_n = r_st == S_IDLE ? bus.addr :
               (r_st == S_RECOV && w_last) ? r_addr + DATA_W'(1) : r_addr;
  end
  // strobes and bus enable are registered from the next state so they change cleanly on phase edges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= S_IDLE;
      r_cnt <= '0;
      r_beats <= '0;
      r_addr <= '0;
      r_rw <= 1'b0;
      r_cs <= 1'b1;
      r_ad <= 1'b1;
      r_rd <= 1'b1;
      r_wr <= 1'b1;
      r_oe <= 1'b0;
      r_dout <= '0;
      r_rdata <= '0;
      r_done <= 1'b0;
      r_rvalid <= 1'b0;
      r_wnext <= 1'b0;
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
      r_irq_pulse <= 1'b0;
    end else begin
      r_st <= w_ns;
      r_cnt <= (w_enter || r_st == S_IDLE) ? '0 : r_cnt + CW'(1);
      r_addr <= w_addr_n;
      r_rw <= r_st == S_IDLE ? bus.rw : r_rw;
      r_beats <= r_st == S_IDLE ? bus.len :
                 (r_st == S_RECOV && w_last) ? r_beats - BURST_W'(1) : r_beats;
      r_cs <= !(w_ns == S_ADDR || w_ns == S_DATA);
      r_ad <= w_ns != S_ADDR;
      r_wr <= !(w_ns == S_ADDR || (w_ns == S_DATA && !r_rw));
      r_rd <= !(w_ns == S_DATA && r_rw);
      r_oe <= w_ns == S_ADDR || (w_ns == S_DATA && !r_rw);
      r_dout <= w_ns == S_ADDR ? w_addr_n :
                (w_ns == S_DATA && w_enter) ? bus.wdata : r_dout;
      r_wnext <= r_st == S_DATA && r_cnt == '0 && !r_rw;
      r_rdata <= (r_st == S_DATA && w_last && r_rw) ? datRTC : r_rdata;
      r_rvalid <= r_st == S_DATA && w_last && r_rw;
      r_done <= r_st == S_RECOV && w_last && r_beats == '0;
      r_s1 <= bus.irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_irq_pulse <= r_s3 && !r_s2;
    end
  end
  assign datRTC = r_oe ? r_dout : 'z;
  assign bus.busy = r_st != S_IDLE;
  assign bus.done = r_done;
  assign bus.rdata = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.wnext = r_wnext;
  assign bus.irq_pulse = r_irq_pulse;
  assign bus.CS = r_cs;
  assign bus.AD = r_ad;
  assign bus.RD = r_rd;
  assign bus.WR = r_wr;
endmodule

// File: doc/rtc_bus_master.md
# rtc_bus_master

Parametrised master for the multiplexed address/data bus of the real-time-clock chip, the next generation of the RTC interface in the top-level package. It sequences address and data phases on `datRTC`/`CS`/`AD`/`RD`/`WR` with programmable phase length, supports multi-register bursts with address auto-increment, and synchronises the RTC interrupt line into a single-cycle pulse. It sits between the control processor's register port and the board-level RTC pins.

## Interface
- `DATA_W`, 8: width of the multiplexed bus, address, and data.
- `PHASE_CYC`, 10: clock cycles per bus phase; must be ≥ 2.
- `BURST_W`, 4: width of `len`; maximum burst is 2^BURST_W beats.

- `clk` in 1: system clock. One clock only.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a transaction; accepted only in IDLE.
- `rw` in 1: 1 = read, 0 = write; latched on accept.
- `addr` in DATA_W: first register address; latched on accept.
- `len` in BURST_W: number of beats minus 1; latched on accept.
- `wdata` in DATA_W: write data; sampled on entry to each DATA phase.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse at the end of the transaction.
- `rdata` out DATA_W: last read byte; holds until the next read beat.
- `rvalid` out 1: one-cycle pulse per read beat.
- `wnext` out 1: one-cycle pulse after each `wdata` sample.
- `irq` in 1: RTC interrupt, active-low, asynchronous.
- `irq_pulse` out 1: one-cycle pulse per falling edge of `irq`.
- `datRTC` inout DATA_W: multiplexed bus. Driven only during ADDR and write DATA phases; high-Z otherwise.
- `CS`, `AD`, `RD`, `WR` out 1 each: active-low bus strobes.

## Operation
- States: IDLE → ADDR → GAP → DATA → RECOV → (ADDR for the next beat | IDLE).
  - A phase counter runs 0..PHASE_CYC-1 in each non-IDLE state.
  - The state advances when the counter reaches PHASE_CYC-1.
- IDLE:
  - All strobes high, `datRTC` Z.
  - On `start`=1, latch `rw`, `addr`, `len` into `cur_addr` and `beats_left`, then go to ADDR.
- ADDR: `CS`=0, `AD`=0, `WR`=0, `RD`=1; `datRTC` = `cur_addr`.
- GAP: all strobes high, `datRTC` Z.
- DATA:
  - `CS`=0, `AD`=1.
  - Write: `WR`=0, `RD`=1; `datRTC` = `wdata` as registered in the first DATA cycle. `wnext` pulses in the second DATA cycle.
  - Read: `RD`=0, `WR`=1, `datRTC` Z. `datRTC` is registered into `rdata` on the last DATA cycle; `rvalid` pulses in the first RECOV cycle.
- RECOV: all strobes high, `datRTC` Z.
  - At the end of RECOV: if `beats_left`=0, go to IDLE and pulse `done` in the first IDLE cycle.
  - Otherwise decrement `beats_left`, set `cur_addr` to `cur_addr`+1 mod 2^DATA_W, and go to ADDR.
- `start` while `busy` is ignored and not queued. `start` in the same cycle that `done` pulses is accepted.
- Interrupt path:
  - Two-flop synchroniser, then falling-edge detect.
  - `irq_pulse` is high for exactly one cycle per high→low transition of the synchronised `irq`.
  - Runs independently of the bus FSM.

## Timing
- Reset values:
  - `CS`=`AD`=`RD`=`WR`=1, `datRTC` Z.
  - `busy`=`done`=`rvalid`=`wnext`=`irq_pulse`=0, `rdata`=0.
  - FSM in IDLE, synchroniser flops set to 1.
- `reset` asserted mid-transaction: on the next edge, the FSM is in IDLE and all outputs are at reset values. No `done` and no `rvalid` is produced for the aborted transaction.
- Accept latency: `start` is sampled at edge N; ADDR (and `busy`=1) begins at edge N+1.
- One beat is exactly 4·PHASE_CYC cycles. A transaction of `len`=L lasts (L+1)·4·PHASE_CYC cycles.
- `done` is asserted at cycle N+1+(L+1)·4·PHASE_CYC, with `busy`=0 in that cycle.
- Strobes and `datRTC` enable are registered outputs, so there are no glitches between phases.
- `irq` falling edge to `irq_pulse` is 3 cycles: 2 synchroniser cycles plus 1 edge-detect register.
- Address wrap: `cur_addr`=2^DATA_W-1 followed by another beat gives 0.

## Test plan
- `PHASE_CYC`=4, single write to `addr`=0x21 with `wdata`=0x5A:
  - `CS` low for cycles 1–4 with `AD`=0 and bus 0x21.
  - `CS` low for cycles 9–12 with `WR`=0 and bus 0x5A.
  - `wnext` at cycle 10, `done` at cycle 17.
- Single read of 0x41 with the bench driving 0x37 while `RD`=0:
  - `rdata`=0x37 and `rvalid` one cycle after the read DATA phase.
  - `datRTC` is never driven by the DUT during DATA.
- Burst read from `addr`=0xFE with `len`=2:
  - Address phases carry 0xFE, 0xFF, 0x00.
  - Three `rvalid` pulses, 16 cycles apart.
  - `done` at cycle 49.
- `start` pulsed while `busy`: no effect on the bus sequence or on `done` count. Back-to-back `start` coincident with `done` starts a new transaction on the next edge.
- `reset` raised during a write DATA phase: next cycle all strobes are 1, `datRTC` Z, `busy`=0, and no `done` pulse.
- `irq` driven 1→0→1→0 with 10-cycle gaps: two `irq_pulse`s, each 3 cycles after its falling edge and each 1 cycle wide. Also check `irq` falling during an active burst.
